// File: rtl/bus_timer_periph.sv
// Memory-mapped prescaled down-counting timer with one-shot / auto-reload modes,
// a sticky expiry flag (write-1-to-clear) and a level interrupt.
module bus_timer_periph #(
   parameter int CNT_W = 32,
   parameter int PSC_W = 16
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        bus_sel,
   input  logic [4:0]  bus_addr,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_PSC    = 3'd1;
   localparam logic [2:0] A_LOAD   = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_COUNT  = 3'd4;

   logic             en;
   logic             auto_reload;
   logic             irq_en;
   logic             flag;
   logic [PSC_W-1:0] prescale;
   logic [PSC_W-1:0] psc_cnt;
   logic [CNT_W-1:0] load;
   logic [CNT_W-1:0] count;

   logic [2:0] reg_idx;
   logic       wr;
   logic       wr_ctrl;
   logic       wr_psc;
   logic       wr_load;
   logic       wr_status;
   logic       tick;
   logic       tick_eff;
   logic       flag_set;

   assign reg_idx   = bus_addr[4:2];
   assign wr        = bus_sel & bus_we;
   assign wr_ctrl   = wr & (reg_idx == A_CTRL);
   assign wr_psc    = wr & (reg_idx == A_PSC);
   assign wr_load   = wr & (reg_idx == A_LOAD);
   assign wr_status = wr & (reg_idx == A_STATUS);

   // A LOAD write in the same cycle swallows the tick entirely.
   assign tick      = en & (psc_cnt == prescale);
   assign tick_eff  = tick & ~wr_load;
   assign flag_set  = tick_eff & (count == CNT_W'(1));

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         en          <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
         flag        <= 1'b0;
         prescale    <= '0;
         psc_cnt     <= '0;
         load        <= '0;
         count       <= '0;
      end else begin
         if (wr_load) begin
            count   <= bus_wdata[CNT_W-1:0];
            psc_cnt <= '0;
         end else begin
            if (en)
               psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
            if (tick) begin
               if (count > CNT_W'(1))
                  count <= count - CNT_W'(1);
               else if (count == CNT_W'(1))
                  count <= auto_reload ? load : '0;
            end
         end

         if (wr_ctrl) begin
            if (!en && bus_wdata[0])
               psc_cnt <= '0;
            en          <= bus_wdata[0];
            auto_reload <= bus_wdata[1];
            irq_en      <= bus_wdata[2];
         end else if (flag_set && !auto_reload) begin
            en <= 1'b0;
         end

         if (wr_psc)
            prescale <= bus_wdata[PSC_W-1:0];
         if (wr_load)
            load <= bus_wdata[CNT_W-1:0];

         // Set beats a simultaneous write-1-to-clear.
         if (flag_set)
            flag <= 1'b1;
         else if (wr_status && bus_wdata[0])
            flag <= 1'b0;
      end
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_sel) begin
         case (reg_idx)
            A_CTRL:   bus_rdata[2:0]       = {irq_en, auto_reload, en};
            A_PSC:    bus_rdata[PSC_W-1:0] = prescale;
            A_LOAD:   bus_rdata[CNT_W-1:0] = load;
            A_STATUS: bus_rdata[0]         = flag;
            A_COUNT:  bus_rdata[CNT_W-1:0] = count;
            default:  bus_rdata            = '0;
         endcase
      end
   end

   assign irq = flag & irq_en;

endmodule
